ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
Shares one simple dual-port RAM (one write port, one read port, registered read data) between NUM_REQ requesters.
- Two independent round-robin arbiters, one for writes and one for reads, so one write and one read can issue in the same cycle.
- Read data returns to the originating requester one cycle after grant, tagged one-hot.
- Sits between the client blocks and the RAM instance; drives all RAM control and address ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, `ADDR_WIDTH, RAM address width
DATA_WIDTH, `DATA_WIDTH, RAM data width
DEPTH, `DEPTH, valid RAM locations (at most 2**ADDR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
wr_valid  in  NUM_REQ  per-requester write request
wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i uses slice i
wr_data  in  NUM_REQ*DATA_WIDTH  packed write data
wr_ready  out  NUM_REQ  write accepted this cycle (one-hot or zero)
rd_valid  in  NUM_REQ  per-requester read request
rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses
rd_ready  out  NUM_REQ  read accepted this cycle (one-hot or zero)
rsp_valid  out  NUM_REQ  read response strobe, one-hot
rsp_err  out  1  qualifies rsp_valid: address was out of range
rsp_data  out  DATA_WIDTH  read data, shared by all requesters
err_cnt  out  8  saturating count of out-of-range accesses, reads and writes
ram_we  out  1  RAM write enable
ram_wr_addr  out  ADDR_WIDTH  RAM write address
ram_wr_din  out  DATA_WIDTH  RAM write data
ram_re  out  1  RAM read enable
ram_rd_addr  out  ADDR_WIDTH  RAM read address
ram_rd_dout  in  DATA_WIDTH  RAM registered read data

Behaviour:
Handshake:
- A request transfers in the cycle where valid and ready are both high.
- valid, addr and data must stay stable until ready. ready is a combinational function of valids and the pointer.
Arbitration:
- Each arbiter keeps a pointer ptr (reset 0) and grants the first valid index scanning ptr, ptr+1, ... mod NUM_REQ.
- On a grant to index g, ptr becomes (g+1) mod NUM_REQ. With no grant, ptr holds.
- The write and read pointers are independent.
Write path:
- Granted and addr < DEPTH: ram_we=1, ram_wr_addr/ram_wr_din = granted slice, same cycle, combinational.
- addr >= DEPTH: request is still accepted (wr_ready=1) but ram_we=0; err_cnt increments.
Read path:
- Granted and in range: ram_re=1, ram_rd_addr = granted slice.
- Next cycle: rsp_valid[g]=1, rsp_data = ram_rd_dout, rsp_err=0.
- Out of range: ram_re=0; next cycle rsp_valid[g]=1, rsp_err=1, rsp_data=0; err_cnt increments.
- Read latency is exactly 1 cycle. Full throughput: one read and one write per cycle.
Hazards and edge cases:
- Same-cycle write and read to the same address: the read returns the old data. This is a documented ordering rule, not an error.
- err_cnt adds 2 when both a read and a write are out of range in the same cycle. It saturates at 255.
- No grant: ram_we=ram_re=0; ram_wr_addr/ram_rd_addr/ram_wr_din driven 0.
Reset:
- All outputs driven 0 while rst is high; readys forced 0; both pointers 0; err_cnt 0; response pipeline flushed.
- A read granted in the cycle before rst asserts produces no rsp_valid.
- The RAM's own rst is wired from the same rst at top level.

Decomposition:
- Shared package: localparam REQ_IDX_W = $clog2(NUM_REQ); typedef for the one-hot grant vector; ERR_CNT_W = 8.
- Natural sub-module rr_arb: NUM_REQ-wide valid in, one-hot grant out, grant_idx out, pointer register inside, pointer advances on any grant.
- Instantiated twice, once for writes and once for reads. The top level holds the range check, muxes, response register and err_cnt.

Test Plan:
Use NUM_REQ=4, ADDR_WIDTH=4, DATA_WIDTH=8, DEPTH=12.
1. Reset, then req0 writes 0xA5 to addr 3; two cycles later req2 reads addr 3 -> wr_ready=0001 same cycle; rd_ready=0100; next cycle rsp_valid=0100, rsp_data=0xA5, rsp_err=0.
2. All four rd_valid held high for 8 cycles, ptr=0 -> grants 0,1,2,3,0,1,2,3; each rsp_valid one-hot one cycle after its grant.
3. req1 writes 0x11 to addr 5 and req3 reads addr 5 in the same cycle (addr 5 previously 0x00) -> both accepted; response 0x00; a re-read next cycle returns 0x11.
4. req0 writes addr 13 and req1 reads addr 14 in the same cycle -> both ready=1, ram_we=0, ram_re=0; next cycle rsp_valid=0010, rsp_err=1, rsp_data=0; err_cnt=2.
5. req2 read granted, rst asserted the next cycle -> rsp_valid stays 0000; pointers and err_cnt reset to 0.
6. 300 out-of-range writes -> err_cnt saturates at 255 and stays there.

Source files
------------

// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and constants for the RAM round-robin arbiter.
//   NUM_REQ_DEF : default requester count
//   REQ_IDX_W   : width of a requester index at the default count
//   grant_t     : one-hot grant vector at the default count
//   ERR_CNT_W   : width of the saturating out-of-range counter
//   err_cnt_add : saturating add of 0..2 error events to the counter
package ram_rr_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int REQ_IDX_W   = $clog2(NUM_REQ_DEF);
    localparam int ERR_CNT_W   = 8;

    typedef logic [NUM_REQ_DEF-1:0] grant_t;
    typedef logic [ERR_CNT_W-1:0]   err_cnt_t;

    function automatic err_cnt_t err_cnt_add(input err_cnt_t cnt, input logic [1:0] inc);
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ram_rr_arbiter_rr_arb.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst    : clock, synchronous active-high reset
//   en          : grants allowed (held low while the top is in reset)
//   valid       : per-requester request
//   grant       : one-hot grant, combinational from valid and the pointer
//   grant_idx   : index of the granted requester
//   grant_any   : some requester was granted
// The pointer names the highest-priority index; after a grant it moves just
// past the winner so the winner becomes lowest priority.
module ram_rr_arbiter_rr_arb
    import ram_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = REQ_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (en && !grant_any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one simple dual-port RAM (one write port, one read port with
// registered read data) between NUM_REQ requesters.
//   clk, rst                      : clock, synchronous active-high reset
//   wr_valid/wr_addr/wr_data      : packed per-requester write requests
//   wr_ready                      : one-hot write accept
//   rd_valid/rd_addr              : packed per-requester read requests
//   rd_ready                      : one-hot read accept
//   rsp_valid/rsp_err/rsp_data    : read response one cycle after accept
//   err_cnt                       : saturating count of out-of-range accesses
//   ram_we/ram_wr_addr/ram_wr_din : RAM write port
//   ram_re/ram_rd_addr/ram_rd_dout: RAM read port
// Out-of-range requests are accepted but never reach the RAM; reads of that
// kind still get a response, flagged with rsp_err and zero data.
module ram_rr_arbiter
    import ram_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            wr_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]            wr_ready,
    input  logic [NUM_REQ-1:0]            rd_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ERR_CNT_W-1:0]          err_cnt,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
    output logic [DATA_WIDTH-1:0]         ram_wr_din,
    output logic                          ram_re,
    output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         ram_rd_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    wr_gnt, rd_gnt;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_any, rd_any;
    logic [ADDR_WIDTH-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_err, rd_err;

    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    err_cnt_t              err_cnt_q, err_cnt_d;
    logic                  rsp_ok;

    ram_rr_arbiter_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (~rst),
        .valid     (wr_valid),
        .grant     (wr_gnt),
        .grant_idx (wr_idx),
        .grant_any (wr_any)
    );

    ram_rr_arbiter_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (~rst),
        .valid     (rd_valid),
        .grant     (rd_gnt),
        .grant_idx (rd_idx),
        .grant_any (rd_any)
    );

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    assign wr_sel_addr = wr_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_sel_data = wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign rd_sel_addr = rd_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
    assign wr_in_range = {1'b0, wr_sel_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign rd_in_range = {1'b0, rd_sel_addr} < (ADDR_WIDTH+1)'(DEPTH);

    assign wr_err = wr_any & ~wr_in_range;
    assign rd_err = rd_any & ~rd_in_range;

    assign ram_we      = wr_any & wr_in_range;
    assign ram_wr_addr = ram_we ? wr_sel_addr : '0;
    assign ram_wr_din  = ram_we ? wr_sel_data : '0;
    assign ram_re      = rd_any & rd_in_range;
    assign ram_rd_addr = ram_re ? rd_sel_addr : '0;

    always_comb begin
        rsp_valid_d = rd_gnt;
        rsp_err_d   = rd_err;
        err_cnt_d   = err_cnt_add(err_cnt_q, {1'b0, wr_err} + {1'b0, rd_err});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Outputs are masked by rst so a read accepted just before reset never
    // surfaces, and nothing is visible before the first reset edge.
    assign rsp_ok    = ~rst & (|rsp_valid_q) & ~rsp_err_q;
    assign rsp_valid = rst ? '0 : rsp_valid_q;
    assign rsp_err   = ~rst & rsp_err_q;
    assign rsp_data  = rsp_ok ? ram_rd_dout : '0;
    assign err_cnt   = rst ? '0 : err_cnt_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
module tb_ram_rr_arbiter;
    import ram_rr_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
    logic [N*AW-1:0]   wr_addr, rd_addr;
    logic [N*DW-1:0]   wr_data;
    logic              rsp_err, ram_we, ram_re;
    logic [DW-1:0]     rsp_data, ram_wr_din, ram_rd_dout;
    logic [7:0]        err_cnt;
    logic [AW-1:0]     ram_wr_addr, ram_rd_addr;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_data    (rsp_data),
        .err_cnt     (err_cnt),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_din  (ram_wr_din),
        .ram_re      (ram_re),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_dout (ram_rd_dout)
    );

    // Environment RAM: registered read, old data on same-cycle write/read.
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (rst) ram_rd_dout <= '0;
        else if (ram_re) ram_rd_dout <= ram_mem[ram_rd_addr];
        if (ram_we) ram_mem[ram_wr_addr] <= ram_wr_din;
    end

    // Requester state (held until accepted)
    logic [N-1:0]  wv, rv;
    logic [AW-1:0] wa [N];
    logic [AW-1:0] ra [N];
    logic [DW-1:0] wd [N];

    // Reference model
    int            m_wptr, m_rptr, m_err;
    logic [DW-1:0] m_mem [2**AW];
    grant_t        p_valid;
    logic          p_err;
    logic [DW-1:0] p_data;

    int     n_cmp = 0;
    int     n_mis = 0;
    grant_t obs_wr_ready, obs_rd_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_cycle();
        int            gw, gr;
        logic          w_in, w_oor, r_in, r_oor;
        grant_t        e_wr, e_rd;
        logic [AW-1:0] e_waddr, e_raddr;
        logic [DW-1:0] e_wdin, e_rdata;
        for (int i = 0; i < N; i++) begin
            wr_addr[i*AW +: AW] = wa[i];
            rd_addr[i*AW +: AW] = ra[i];
            wr_data[i*DW +: DW] = wd[i];
        end
        wr_valid = wv;
        rd_valid = rv;
        #1;
        gw = rst ? -1 : pick(wv, m_wptr);
        gr = rst ? -1 : pick(rv, m_rptr);
        e_wr = '0; e_rd = '0; w_in = 0; w_oor = 0; r_in = 0; r_oor = 0;
        e_waddr = '0; e_wdin = '0; e_raddr = '0; e_rdata = '0;
        if (gw >= 0) begin
            e_wr[gw] = 1'b1;
            w_in  = int'(wa[gw]) < DEPTH;
            w_oor = !w_in;
            if (w_in) begin e_waddr = wa[gw]; e_wdin = wd[gw]; end
        end
        if (gr >= 0) begin
            e_rd[gr] = 1'b1;
            r_in  = int'(ra[gr]) < DEPTH;
            r_oor = !r_in;
            if (r_in) begin e_raddr = ra[gr]; e_rdata = m_mem[ra[gr]]; end
        end
        obs_wr_ready = wr_ready;
        obs_rd_ready = rd_ready;
        chk("wr_ready", wr_ready, e_wr);
        chk("rd_ready", rd_ready, e_rd);
        chk("ram_we", ram_we, w_in);
        chk("ram_wr_addr", ram_wr_addr, e_waddr);
        chk("ram_wr_din", ram_wr_din, e_wdin);
        chk("ram_re", ram_re, r_in);
        chk("ram_rd_addr", ram_rd_addr, e_raddr);
        chk("rsp_valid", rsp_valid, rst ? '0 : p_valid);
        chk("rsp_err", rsp_err, rst ? 1'b0 : p_err);
        chk("rsp_data", rsp_data, rst ? '0 : p_data);
        chk("err_cnt", err_cnt, rst ? 0 : m_err);
        @(posedge clk);
        if (rst) begin
            m_wptr = 0; m_rptr = 0; m_err = 0;
            p_valid = '0; p_err = 1'b0; p_data = '0;
        end else begin
            p_valid = e_rd;
            p_err   = r_oor;
            p_data  = e_rdata;
            if (w_in) m_mem[wa[gw]] = wd[gw];
            if (gw >= 0) begin m_wptr = (gw + 1) % N; wv[gw] = 1'b0; end
            if (gr >= 0) begin m_rptr = (gr + 1) % N; rv[gr] = 1'b0; end
            m_err = m_err + int'(w_oor) + int'(r_oor);
            if (m_err > 255) m_err = 255;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wv = '0; rv = '0;
        do_cycle();
        do_cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        for (int i = 0; i < N; i++) begin
            wa[i] = '0; ra[i] = '0; wd[i] = '0;
        end
        ram_rd_dout = '0;
        m_wptr = 0; m_rptr = 0; m_err = 0;
        p_valid = '0; p_err = 1'b0; p_data = '0;
        wv = '0; rv = '0;
        do_reset();

        // 1: write then read back through a different requester
        wv[0] = 1'b1; wa[0] = 4'd3; wd[0] = 8'hA5;
        do_cycle();
        chk("t1_wr_ready", obs_wr_ready, 4'b0001);
        do_cycle();
        rv[2] = 1'b1; ra[2] = 4'd3;
        do_cycle();
        chk("t1_rd_ready", obs_rd_ready, 4'b0100);
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_data", rsp_data, 8'hA5);
        chk("t1_rsp_err", rsp_err, 1'b0);

        // 2: all readers busy, pointer rotates from 0
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) ra[i] = AW'(i);
            rv = '1;
            do_cycle();
            chk("t2_grant", obs_rd_ready, 4'b0001 << (k % N));
            chk("t2_rsp_valid", rsp_valid, 4'b0001 << (k % N));
        end
        rv = '0;
        do_cycle();

        // 3: same-cycle write and read of one address returns old data
        wv[1] = 1'b1; wa[1] = 4'd5; wd[1] = 8'h11;
        rv[3] = 1'b1; ra[3] = 4'd5;
        do_cycle();
        chk("t3_old_data", rsp_data, 8'h00);
        rv[3] = 1'b1; ra[3] = 4'd5;
        do_cycle();
        chk("t3_new_data", rsp_data, 8'h11);

        // 4: both out of range in one cycle
        wv[0] = 1'b1; wa[0] = 4'd13; wd[0] = 8'h77;
        rv[1] = 1'b1; ra[1] = 4'd14;
        do_cycle();
        chk("t4_rsp_valid", rsp_valid, 4'b0010);
        chk("t4_rsp_err", rsp_err, 1'b1);
        chk("t4_rsp_data", rsp_data, 8'h00);
        chk("t4_err_cnt", err_cnt, 8'd2);

        // 5: read accepted just before reset must not respond
        rv[2] = 1'b1; ra[2] = 4'd0;
        do_cycle();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        wv = '1; rv = '1;
        for (int i = 0; i < N; i++) begin wa[i] = 4'd1; ra[i] = 4'd1; end
        do_cycle();
        chk("t5_wptr", obs_wr_ready, 4'b0001);
        chk("t5_rptr", obs_rd_ready, 4'b0001);
        chk("t5_err_cnt", err_cnt, 8'd0);
        wv = '0; rv = '0;
        do_cycle();

        // 6: counter saturation
        for (int k = 0; k < 300; k++) begin
            wv[0] = 1'b1; wa[0] = 4'd15;
            do_cycle();
        end
        chk("t6_err_sat", err_cnt, 8'd255);

        // Randomised traffic with occasional reset
        do_reset();
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!wv[i] && $urandom_range(0, 99) < 50) begin
                    wv[i] = 1'b1;
                    wa[i] = AW'($urandom_range(0, 15));
                    wd[i] = DW'($urandom);
                end
                if (!rv[i] && $urandom_range(0, 99) < 50) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(0, 15));
                end
            end
            rst = ($urandom_range(0, 59) == 0);
            do_cycle();
        end
        rst = 1'b0;
        wv = '0; rv = '0;
        do_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
